// File: rtl/dram_pkg.sv
// Shared DRAM controller types, default timing values and state-class helpers.
// cmd_state_t is the registered state of the DRAM command FSM.
package dram_pkg;

  typedef enum logic [3:0] {
    IDLE,
    POWER_UP,
    ACTIVATE,
    ACTIVATING,
    READ,
    READING,
    WRITE,
    WRITING,
    PRECHARGE,
    PRECHARGING,
    PRECHARGE_RE,
    PRECHARGING_RE,
    REFRESH,
    REFRESHING
  } cmd_state_t;

  localparam int unsigned DEF_TRCD         = 14;
  localparam int unsigned DEF_TCL          = 14;
  localparam int unsigned DEF_TCWL         = 12;
  localparam int unsigned DEF_TBURST       = 4;
  localparam int unsigned DEF_TWR          = 16;
  localparam int unsigned DEF_TRP          = 14;
  localparam int unsigned DEF_TRFC         = 350;
  localparam int unsigned DEF_TREFI        = 7800;
  localparam int unsigned DEF_MAX_POSTPONE = 8;
  localparam int unsigned DEF_TIMER_W      = 10;

  function automatic logic is_issue_state(input cmd_state_t s);
    case (s)
      ACTIVATE, READ, WRITE, PRECHARGE, PRECHARGE_RE, REFRESH: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_wait_state(input cmd_state_t s);
    case (s)
      ACTIVATING, READING, WRITING,
      PRECHARGING, PRECHARGING_RE, REFRESHING: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dram_down_timer.sv
// Loadable down-counter with an armed flag, so that a zero count only means
// "done" when a period was actually started.
module dram_down_timer #(
  parameter int unsigned W = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero,
  output logic         armed
);

  logic [W-1:0] timer;

  assign zero = (timer == '0);

  // Reaching zero while enabled is the done cycle; armed drops after it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      timer <= '0;
      armed <= 1'b0;
    end else if (load) begin
      timer <= load_val;
      armed <= 1'b1;
    end else if (en) begin
      if (timer != '0) timer <= timer - 1'b1;
      else             armed <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_timing_ctrl.sv
// Timing companion to the DRAM command FSM: command-period done strobes from one
// shared down-timer, plus the tREFI refresh scheduler with a postponement budget.
module dram_timing_ctrl
  import dram_pkg::*;
#(
  parameter int unsigned tRCD         = DEF_TRCD,
  parameter int unsigned tCL          = DEF_TCL,
  parameter int unsigned tCWL         = DEF_TCWL,
  parameter int unsigned tBURST       = DEF_TBURST,
  parameter int unsigned tWR          = DEF_TWR,
  parameter int unsigned tRP          = DEF_TRP,
  parameter int unsigned tRFC         = DEF_TRFC,
  parameter int unsigned tREFI        = DEF_TREFI,
  parameter int unsigned MAX_POSTPONE = DEF_MAX_POSTPONE,
  parameter int unsigned TIMER_W      = DEF_TIMER_W
) (
  input  logic       CLK,
  input  logic       RST,
  input  cmd_state_t cmd_state,
  output logic       tACT_done,
  output logic       tRD_done,
  output logic       tWR_done,
  output logic       tPRE_done,
  output logic       tREF_done,
  output logic       rf_req,
  output logic       rf_urgent,
  output logic       rf_overflow
);

  localparam int unsigned L_ACT   = tRCD;
  localparam int unsigned L_RD    = tCL + tBURST;
  localparam int unsigned L_WR    = tCWL + tBURST + tWR;
  localparam int unsigned L_PRE   = tRP;
  localparam int unsigned L_REF   = tRFC;
  localparam int unsigned L_LIMIT = (2 ** TIMER_W) - 1;

  localparam int unsigned REFI_W = (tREFI > 2) ? $clog2(tREFI) : 1;
  localparam int unsigned OWED_W = $clog2(MAX_POSTPONE + 1);

  localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(tREFI - 1);
  localparam logic [OWED_W-1:0] OWED_MAX  = OWED_W'(MAX_POSTPONE);

  generate
    if (tRCD < 1 || tRP < 1 || tRFC < 1) begin : g_bad_min
      $error("dram_timing_ctrl: tRCD, tRP and tRFC must all be at least 1");
    end
    if (tREFI < 2) begin : g_bad_refi
      $error("dram_timing_ctrl: tREFI must be at least 2");
    end
    if (L_ACT > L_LIMIT || L_RD > L_LIMIT || L_WR > L_LIMIT ||
        L_PRE > L_LIMIT || L_REF > L_LIMIT) begin : g_bad_width
      $error("dram_timing_ctrl: a load value does not fit in TIMER_W bits");
    end
  endgenerate

  // Command-period timer: loaded with L-1 so done lands exactly L cycles after issue.
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_zero;
  logic               tmr_armed;
  logic [TIMER_W-1:0] tmr_load_val;

  assign tmr_load = is_issue_state(cmd_state);
  assign tmr_en   = is_wait_state(cmd_state);

  always_comb begin
    tmr_load_val = '0;
    case (cmd_state)
      ACTIVATE:               tmr_load_val = TIMER_W'(L_ACT - 1);
      READ:                   tmr_load_val = TIMER_W'(L_RD - 1);
      WRITE:                  tmr_load_val = TIMER_W'(L_WR - 1);
      PRECHARGE, PRECHARGE_RE: tmr_load_val = TIMER_W'(L_PRE - 1);
      REFRESH:                tmr_load_val = TIMER_W'(L_REF - 1);
      default:                tmr_load_val = '0;
    endcase
  end

  dram_down_timer #(
    .W (TIMER_W)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (tmr_zero),
    .armed    (tmr_armed)
  );

  logic period_done;
  assign period_done = tmr_armed & tmr_zero;

  assign tACT_done = period_done & (cmd_state == ACTIVATING);
  assign tRD_done  = period_done & (cmd_state == READING);
  assign tWR_done  = period_done & (cmd_state == WRITING);
  assign tPRE_done = period_done & ((cmd_state == PRECHARGING) ||
                                    (cmd_state == PRECHARGING_RE));
  assign tREF_done = period_done & (cmd_state == REFRESHING);

  // Refresh scheduler: one refresh becomes owed per tREFI wrap, REFRESH pays one back.
  logic [REFI_W-1:0] refi_cnt;
  logic [OWED_W-1:0] owed;
  logic              tick;
  logic              do_ref;

  assign tick   = (cmd_state != POWER_UP) && (refi_cnt == REFI_LAST);
  assign do_ref = (cmd_state == REFRESH);

  always_ff @(posedge CLK) begin
    if (RST) begin
      refi_cnt    <= '0;
      owed        <= '0;
      rf_overflow <= 1'b0;
    end else begin
      if (cmd_state == POWER_UP || tick) refi_cnt <= '0;
      else                               refi_cnt <= refi_cnt + 1'b1;

      if (tick && !do_ref) begin
        if (owed == OWED_MAX) rf_overflow <= 1'b1;
        else                  owed        <= owed + 1'b1;
      end else if (do_ref && !tick && owed != '0) begin
        owed <= owed - 1'b1;
      end
    end
  end

  assign rf_req    = (owed != '0);
  assign rf_urgent = (owed == OWED_MAX);

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// Directed bench for dram_timing_ctrl with a short refresh interval (tREFI=16, MAX_POSTPONE=2).
module tb_dram_timing_ctrl;
  import dram_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  cmd_state_t cmd_state = POWER_UP;

  logic tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done;
  logic rf_req, rf_urgent, rf_overflow;

  logic [4:0] dones;
  logic [2:0] rfv;

  int checks = 0;
  int errors = 0;

  dram_timing_ctrl #(
    .tREFI        (16),
    .MAX_POSTPONE (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .cmd_state   (cmd_state),
    .tACT_done   (tACT_done),
    .tRD_done    (tRD_done),
    .tWR_done    (tWR_done),
    .tPRE_done   (tPRE_done),
    .tREF_done   (tREF_done),
    .rf_req      (rf_req),
    .rf_urgent   (rf_urgent),
    .rf_overflow (rf_overflow)
  );

  always #5 CLK = ~CLK;

  assign dones = {tREF_done, tPRE_done, tWR_done, tRD_done, tACT_done};
  assign rfv   = {rf_overflow, rf_urgent, rf_req};

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic set_cmd(input cmd_state_t c);
    cmd_state = c;
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue for one cycle, then wait; done must appear exactly lat cycles after issue.
  task automatic run_op(input cmd_state_t iss, input cmd_state_t wt, input int lat,
                        input logic [4:0] exp, input string tag);
    set_cmd(iss);
    step();
    set_cmd(wt);
    for (int k = 1; k < lat; k++) begin
      chk({tag, "_early"}, 8'(dones), 8'h00);
      step();
    end
    chk(tag, 8'(dones), 8'(exp));
  endtask

  initial begin
    // Reset state
    RST = 1'b1;
    set_cmd(POWER_UP);
    step(2);
    RST = 1'b0;
    set_cmd(IDLE);
    chk("reset_dones", 8'(dones), 8'h00);
    chk("reset_rf", 8'(rfv), 8'h00);

    // Activate, read, write, back-to-back precharge
    run_op(ACTIVATE, ACTIVATING, 14, 5'b00001, "act_done");
    step();
    run_op(READ, READING, 18, 5'b00010, "rd_done");
    step();
    run_op(WRITE, WRITING, 32, 5'b00100, "wr_done");
    step();
    run_op(PRECHARGE, PRECHARGING, 14, 5'b01000, "pre_done");
    step();
    run_op(PRECHARGE_RE, PRECHARGING_RE, 14, 5'b01000, "pre_re_done");

    // Refresh scheduling from a known interval phase
    RST = 1'b1;
    set_cmd(POWER_UP);
    step();
    RST = 1'b0;
    step(3);
    set_cmd(IDLE);
    chk("refi_c0", 8'(rfv), 8'h00);
    step(15);
    chk("refi_c15", 8'(rfv), 8'h00);
    step();
    chk("refi_c16_req", 8'(rfv), 8'h01);
    step(15);
    chk("refi_c31", 8'(rfv), 8'h01);
    step();
    chk("refi_c32_urgent", 8'(rfv), 8'h03);
    step(15);
    chk("refi_c47", 8'(rfv), 8'h03);
    step();
    chk("refi_c48_overflow", 8'(rfv), 8'h07);
    set_cmd(REFRESH);
    step();
    set_cmd(IDLE);
    chk("refresh_pays_one", 8'(rfv), 8'h05);

    // Coincident tick and REFRESH, then REFRESH with nothing owed
    step(14);
    set_cmd(REFRESH);
    step();
    set_cmd(IDLE);
    chk("tick_plus_refresh", 8'(rfv), 8'h05);
    set_cmd(REFRESH);
    step();
    chk("owed_to_zero", 8'(rfv), 8'h04);
    step();
    set_cmd(IDLE);
    chk("no_underflow", 8'(rfv), 8'h04);
    run_op(REFRESH, REFRESHING, 350, 5'b10000, "ref_done");

    // Unarmed wait state
    RST = 1'b1;
    step();
    RST = 1'b0;
    set_cmd(READING);
    for (int k = 0; k < 100; k++) begin
      chk("unarmed_read", 8'(dones), 8'h00);
      step();
    end

    // Reset in the middle of a write period
    set_cmd(WRITE);
    step();
    set_cmd(WRITING);
    step(10);
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    chk("midreset_dones", 8'(dones), 8'h00);
    chk("midreset_rf", 8'(rfv), 8'h00);
    for (int k = 0; k < 40; k++) begin
      step();
      chk("midreset_no_wr_done", 8'(tWR_done), 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
